// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the hazard control unit: FSM encoding,
// the architectural zero register and the bundled control-output struct.
package hazard_control_unit_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MULDIV = 1'b1
  } hcu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
    logic muldiv_busy;
    logic muldiv_done;
  } hcu_ctrl_t;

  // Free-running pipeline: everything advances, nothing is squashed.
  localparam hcu_ctrl_t CTRL_DEFAULT = '{
    pc_write:      1'b1,
    if_id_write:   1'b1,
    id_ex_write:   1'b1,
    if_id_flush:   1'b0,
    id_ex_flush:   1'b0,
    ex_mem_bubble: 1'b0,
    muldiv_busy:   1'b0,
    muldiv_done:   1'b0
  };

  // Held in reset: freeze fetch and fill every downstream stage with bubbles.
  localparam hcu_ctrl_t CTRL_RESET = '{
    pc_write:      1'b0,
    if_id_write:   1'b0,
    id_ex_write:   1'b0,
    if_id_flush:   1'b1,
    id_ex_flush:   1'b1,
    ex_mem_bubble: 1'b1,
    muldiv_busy:   1'b0,
    muldiv_done:   1'b0
  };

endpackage

// File: rtl/hazard_control_unit_load_use_detect.sv
// Combinational load-use detector: a load in EX whose non-zero destination
// feeds either source of the instruction currently in ID.
module load_use_detect
  import hazard_control_unit_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard
);

  assign hazard = mem_read && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes and a
// two-state FSM that freezes the front end for multi-cycle MUL/DIV ops.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ID_EX_MemRead,
  input  logic [4:0]             ID_EX_RegisterRd,
  input  logic [4:0]             IF_ID_RegisterRs1,
  input  logic [4:0]             IF_ID_RegisterRs2,
  input  logic                   EX_BranchTaken,
  input  logic                   EX_MulDivStart,
  output logic                   PCWrite,
  output logic                   IF_ID_Write,
  output logic                   ID_EX_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Flush,
  output logic                   EX_MEM_Bubble,
  output logic                   MulDivBusy,
  output logic                   MulDivDone,
  output logic [STALL_CNT_W-1:0] StallCount
);

  localparam int CNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;

  hcu_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  hcu_ctrl_t              ctrl;
  logic                   load_use;

  load_use_detect u_load_use_detect (
    .mem_read (ID_EX_MemRead),
    .rd       (ID_EX_RegisterRd),
    .rs1      (IF_ID_RegisterRs1),
    .rs2      (IF_ID_RegisterRs2),
    .hazard   (load_use)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_DEFAULT;

    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (EX_BranchTaken) begin
            // A taken branch squashes a simultaneous MUL/DIV start and any load-use stall.
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (EX_MulDivStart) begin
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            ctrl.id_ex_write   = 1'b0;
            ctrl.ex_mem_bubble = 1'b1;
            state_d            = ST_MULDIV;
            cnt_d              = CNT_W'(MULDIV_CYCLES - 2);
          end else if (load_use) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end
        end
        ST_MULDIV: begin
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          ctrl.id_ex_write = 1'b0;
          ctrl.muldiv_busy = 1'b1;
          if (cnt_q == '0) begin
            // Last cycle: let the result move into MEM while the front end stays held.
            ctrl.muldiv_done = 1'b1;
            state_d          = ST_RUN;
          end else begin
            ctrl.ex_mem_bubble = 1'b1;
            cnt_d              = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign PCWrite       = ctrl.pc_write;
  assign IF_ID_Write   = ctrl.if_id_write;
  assign ID_EX_Write   = ctrl.id_ex_write;
  assign IF_ID_Flush   = ctrl.if_id_flush;
  assign ID_EX_Flush   = ctrl.id_ex_flush;
  assign EX_MEM_Bubble = ctrl.ex_mem_bubble;
  assign MulDivBusy    = ctrl.muldiv_busy;
  assign MulDivDone    = ctrl.muldiv_done;
  assign StallCount    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized scoreboard bench for hazard_control_unit: a behavioural model
// predicts each cycle's controls; a negedge monitor compares both DUT instances.
module tb_hazard_control_unit;

  localparam int MD_CYC = 4;

  typedef struct packed {
    logic        pc;
    logic        ifid_w;
    logic        idex_w;
    logic        ifid_f;
    logic        idex_f;
    logic        bubble;
    logic        busy;
    logic        done;
    logic [15:0] sc;
    logic [1:0]  sc_sat;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic       br = 1'b0, md = 1'b0;

  logic        pc_w, ifid_w, idex_w, ifid_f, idex_f, bubble, busy, done;
  logic [15:0] sc;
  logic        s_pc_w, s_ifid_w, s_idex_w, s_ifid_f, s_idex_f, s_bubble, s_busy, s_done;
  logic [1:0]  s_sc;

  always #5 clk = ~clk;

  hazard_control_unit #(.MULDIV_CYCLES(MD_CYC), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRd(rd),
    .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
    .EX_BranchTaken(br), .EX_MulDivStart(md),
    .PCWrite(pc_w), .IF_ID_Write(ifid_w), .ID_EX_Write(idex_w),
    .IF_ID_Flush(ifid_f), .ID_EX_Flush(idex_f), .EX_MEM_Bubble(bubble),
    .MulDivBusy(busy), .MulDivDone(done), .StallCount(sc)
  );

  hazard_control_unit #(.MULDIV_CYCLES(MD_CYC), .STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRd(rd),
    .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
    .EX_BranchTaken(br), .EX_MulDivStart(md),
    .PCWrite(s_pc_w), .IF_ID_Write(s_ifid_w), .ID_EX_Write(s_idex_w),
    .IF_ID_Flush(s_ifid_f), .ID_EX_Flush(s_idex_f), .EX_MEM_Bubble(s_bubble),
    .MulDivBusy(s_busy), .MulDivDone(s_done), .StallCount(s_sc)
  );

  // Reference model state: cycles of front-end freeze still owed to a MUL/DIV op,
  // and stalled-edge tallies clamped at each counter's ceiling.
  int   freeze_left = 0;
  int   stalls      = 0;
  int   stalls_sat  = 0;
  obs_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic step(input logic r, input logic m, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic b, input logic st);
    obs_t e;
    @(posedge clk);
    #1;
    rst = r; mem_read = m; rd = d; rs1 = s1; rs2 = s2; br = b; md = st;
    e = '{pc: 1'b1, ifid_w: 1'b1, idex_w: 1'b1, default: '0};
    if (r) begin
      freeze_left = 0;
      stalls      = 0;
      stalls_sat  = 0;
      e.pc = 1'b0; e.ifid_w = 1'b0; e.idex_w = 1'b0;
      e.ifid_f = 1'b1; e.idex_f = 1'b1; e.bubble = 1'b1;
    end else begin
      e.sc     = 16'(stalls);
      e.sc_sat = 2'(stalls_sat);
      if (freeze_left > 0) begin
        e.pc = 1'b0; e.ifid_w = 1'b0; e.idex_w = 1'b0; e.busy = 1'b1;
        e.done   = (freeze_left == 1);
        e.bubble = (freeze_left != 1);
        freeze_left--;
      end else if (b) begin
        e.ifid_f = 1'b1; e.idex_f = 1'b1;
      end else if (st) begin
        e.pc = 1'b0; e.ifid_w = 1'b0; e.idex_w = 1'b0; e.bubble = 1'b1;
        freeze_left = MD_CYC - 1;
      end else if (m && d != 0 && (d == s1 || d == s2)) begin
        e.pc = 1'b0; e.ifid_w = 1'b0; e.idex_f = 1'b1;
      end
      if (!e.pc) begin
        if (stalls < 65535) stalls++;
        if (stalls_sat < 3) stalls_sat++;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{pc: pc_w, ifid_w: ifid_w, idex_w: idex_w, ifid_f: ifid_f, idex_f: idex_f,
              bubble: bubble, busy: busy, done: done, sc: sc, sc_sat: s_sc};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_outputs at cycle %0d: got %h expected %h (pc,ifw,idw,iff,idf,bub,busy,done | sc | sc2)",
                   cyc, a, e);
        end
      end
    end
  end

  initial begin : stimulus
    @(posedge clk);
    // Reset held, then released with quiet inputs.
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(1);
    // Load-use on rs1, then quiet cycle showing StallCount=1.
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    idle(1);
    // Load to x0 matching rs2=x0: no stall.
    step(1'b0, 1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
    // Branch coincident with load-use.
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    // Branch coincident with MUL/DIV start: op must not start.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    idle(1);
    // Full MUL/DIV op with noisy inputs during MULDIV, which must be ignored.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
    idle(3);
    // Reset on the 2nd cycle of an op, then release.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(2);
    // Five consecutive load-use stalls after a reset: 2-bit counter holds at 3.
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0);
    idle(2);
    // Randomized traffic over a narrow register range to provoke frequent hits.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0));
    end
    idle(1);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
